fir_mac_datapath: RTL
=====================

# fir_mac_datapath

Two-MAC arithmetic datapath of the reconfigurable 21-tap FIR filter, directly downstream of the control FSM and the split coefficient SRAM. It holds the 21-sample delay line and snoops the FSM's SRAM read strobes. Each read beat multiplies two taps by two coefficients, one from each SRAM bank, into two accumulators. It then sums, rounds, limits and registers one filter output per 600 kHz sample.

## Interface
- DATA_W, 16: signed width of input sample, coefficients and output.
- FRAC_W, 15: fractional bits of coefficients; the output is the sum shifted right by FRAC_W.
- iClk  in  1  single clock; every register is clocked on its rising edge.
- iRsn  in  1  asynchronous, active-low reset.
- iEnSample600k  in  1  one-cycle sample strobe; iFirIn is valid on this cycle.
- iFirIn  in  DATA_W  signed input sample.
- iCsn  in  1  FSM SRAM chip select, active low.
- iWrn  in  1  FSM SRAM write enable, low = write.
- iAddr  in  5  FSM SRAM address.
- iRdData1  in  DATA_W  bank-1 read data: coefficient k, for k = 0..10.
- iRdData2  in  DATA_W  bank-2 read data: coefficient k+11, for k = 0..9.
- iEnOut  in  1  FSM output-enable pulse (OUTPUT state).
- oFirOut  out  DATA_W  filtered sample; reset 0.
- oFirOutValid  out  1  one-cycle pulse when oFirOut updates; reset 0.
- oOverrun  out  1  sticky: a sample was lost; reset 0; cleared only by iRsn.

## Operation
- **Delay line.** rTap[0..20], where rTap[0] is the newest sample.
  - On iEnSample600k with the block not busy: rTap[0] <= iFirIn and rTap[i] <= rTap[i-1].
  - If iEnSample600k arrives while busy: iFirIn goes into a pending register, and the shift is applied in the cycle after the sum is registered.
  - A second strobe while a sample is pending overwrites the pending sample and sets oOverrun.
- **Beat detect.** A registered copy of (!iCsn && iWrn) plus a registered copy of iAddr, modelling the 1-cycle synchronous SRAM read latency, form a read beat at index k in the following cycle.
  - Beats with k > 10 are ignored.
  - Write cycles (iWrn = 0) are never beats.
- **MAC.**
  - Beat with k = 0: clear-and-load. rAcc1 = rTap[0]*iRdData1 and rAcc2 = rTap[11]*iRdData2, discarding any earlier contents. This makes the stale FETCH-cycle address harmless. Busy is set.
  - Beat with 1 <= k <= 9: rAcc1 += rTap[k]*iRdData1 and rAcc2 += rTap[k+11]*iRdData2.
  - Beat with k = 10: rAcc1 += rTap[10]*iRdData1; rAcc2 is unchanged and iRdData2 is ignored. This beat sets done.
  - A beat at k = 10 without a preceding k = 0 beat still updates rAcc1 and still sets done.
- **Internal FSM.**
  - IDLE -> ACC on the k = 0 beat.
  - ACC -> SUM on the k = 10 beat.
  - SUM: rSum <= rAcc1 + rAcc2; then go to WAIT.
  - WAIT -> IDLE on iEnOut. An iEnOut seen while in IDLE, ACC or SUM is ignored.
  - Busy = ACC or SUM.
- **Widths.**
  - Products: 2*DATA_W signed.
  - Accumulators: 2*DATA_W+4 signed (11 terms).
  - rSum: 2*DATA_W+5 signed.
  - Output value: (rSum + 2^(FRAC_W-1)) >>> FRAC_W, i.e. round half up, then limited to DATA_W as described under Configuration.

## Timing
- Let T be the cycle the FSM presents address 10.
  - T+1: k = 10 beat; accumulators final at the end of the cycle.
  - T+2: SUM; rSum registered.
  - T+3: iEnOut arrives; oFirOut is registered at the end of T+3.
  - T+4: oFirOutValid high for exactly one cycle.
- oFirOut holds its value until the next update.
- A deferred sample shift happens at T+3.
- iEnSample600k coincident with the k = 0 beat: the strobe is treated as busy and the sample is deferred. The strobe normally precedes the FSM's FETCH, so this is an abnormal case.
- iRsn low at any time, including mid-accumulation: all registers, pending flag and FSM clear immediately; no output pulse follows.

## Configuration
- FIR_OUT_SAT_EN defined: the rounded result is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_OUT_SAT_EN undefined: the rounded result is truncated to its DATA_W LSBs (two's-complement wrap).

## Test plan
- **Impulse.**
  - Stimulus: coefficients c[k] = k+1 (Q1.15 raw); one strobe with iFirIn = 0x7FFF (32767) followed by zeros; after each strobe drive FETCH (stale iAddr = 10, then addresses 0..10) and iEnOut at T+3.
  - Response: successive outputs = round(32767*c[n] / 2^15), i.e. 1, 2, 3, ... 21, then 0.
- **Saturation.**
  - Stimulus: all 21 coefficients 0x7FFF; fill the delay line with 0x7FFF.
  - Response: oFirOut = 0x7FFF with FIR_OUT_SAT_EN; the wrapped value without it.
- **Stale FETCH address.**
  - Stimulus: address 10 beat, then beats 0..10.
  - Response: result identical to a clean 0..10 sweep.
- **Write isolation.** Stimulus: iWrn = 0 cycles (COEFFWR addresses 0..20) mid-idle. Response: accumulators and oFirOutValid unchanged.
- **Deferred sample and overrun.**
  - One strobe during ACC: the shift lands at T+3 and oOverrun stays 0.
  - Two strobes during ACC: the second sample is used and oOverrun = 1.
- **Reset mid-accumulation.** Stimulus: iRsn low for 1 cycle at beat k = 5. Response: all outputs 0 at once; no oFirOutValid pulse until a fresh 0..10 sweep completes.

Source files
------------

// File: rtl/fir_mac_datapath_if.sv
// fir_mac_datapath_if
// Read/write bus between the FIR control FSM, the split coefficient SRAM
// and the MAC datapath. The FSM/SRAM side drives every signal; the datapath
// only snoops them.
//   iCsn      SRAM chip select, active low
//   iWrn      SRAM write enable, low = write
//   iAddr     SRAM address presented by the FSM
//   iRdData1  bank-1 read data (coefficient k)
//   iRdData2  bank-2 read data (coefficient k+11)
interface fir_mac_datapath_if #(
  parameter int DATA_W = 16
);
  logic                     iCsn;
  logic                     iWrn;
  logic [4:0]               iAddr;
  logic signed [DATA_W-1:0] iRdData1;
  logic signed [DATA_W-1:0] iRdData2;

  modport master (output iCsn, iWrn, iAddr, iRdData1, iRdData2);
  modport slave  (input  iCsn, iWrn, iAddr, iRdData1, iRdData2);
endinterface

// File: rtl/fir_mac_datapath.sv
// fir_mac_datapath
// Two-MAC datapath of the 21-tap FIR. Holds the delay line, snoops the FSM's
// SRAM read strobes (one beat = two taps x two coefficients), then sums,
// rounds, limits and registers one output per sample.
// Optional feature macro: FIR_OUT_SAT_EN (saturate the rounded result;
// when undefined the result wraps to DATA_W bits).
// Ports:
//   iClk, iRsn       clock, asynchronous active-low reset
//   iEnSample600k    sample strobe, iFirIn valid on this cycle
//   iFirIn           signed input sample
//   sram             snooped SRAM bus (slave modport)
//   iEnOut           FSM output-enable pulse
//   oFirOut          filtered sample, held until next update
//   oFirOutValid     one-cycle pulse when oFirOut updates
//   oOverrun         sticky: a pending sample was overwritten
//
// state  | meaning
// S_IDLE | waiting for the k = 0 read beat
// S_ACC  | accumulating beats k = 1..10
// S_SUM  | registering rAcc1 + rAcc2 into rSum
// S_WAIT | sum ready, waiting for iEnOut
module fir_mac_datapath #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic                     iEnSample600k,
  input  logic signed [DATA_W-1:0] iFirIn,
  fir_mac_datapath_if.slave        sram,
  input  logic                     iEnOut,
  output logic signed [DATA_W-1:0] oFirOut,
  output logic                     oFirOutValid,
  output logic                     oOverrun
);
  localparam int N_TAPS = 21;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam int SUM_W  = PROD_W + 5;
  localparam logic signed [SUM_W-1:0] ROUND_HALF = SUM_W'(1) <<< (FRAC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SUM, S_WAIT} state_t;

  state_t                   rState;
  logic                     rBeatRd;
  logic [4:0]               rBeatAddr;
  logic                     beat;
  logic                     beatFirst;
  logic                     beatLast;
  logic                     busyNow;
  logic signed [DATA_W-1:0] rTap [N_TAPS];
  logic signed [DATA_W-1:0] rPend;
  logic                     rPendValid;
  logic                     doShift;
  logic signed [DATA_W-1:0] shiftIn;
  logic signed [DATA_W-1:0] tapA;
  logic signed [DATA_W-1:0] tapB;
  logic signed [PROD_W-1:0] prod1;
  logic signed [PROD_W-1:0] prod2;
  logic signed [ACC_W-1:0]  rAcc1;
  logic signed [ACC_W-1:0]  rAcc2;
  logic signed [SUM_W-1:0]  rSum;
  logic signed [SUM_W-1:0]  rounded;
  logic signed [DATA_W-1:0] outVal;

  // The SRAM answers one cycle after the address, so the beat is formed
  // from registered copies of the read strobe and address.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rBeatRd   <= 1'b0;
      rBeatAddr <= '0;
    end else begin
      rBeatRd   <= !sram.iCsn && sram.iWrn;
      rBeatAddr <= sram.iAddr;
    end
  end

  assign beat      = rBeatRd && (rBeatAddr <= 5'd10);
  assign beatFirst = beat && (rBeatAddr == 5'd0);
  assign beatLast  = beat && (rBeatAddr == 5'd10);
  // A strobe coinciding with the k = 0 beat must not disturb the taps the
  // sweep is about to read, so it counts as busy.
  assign busyNow   = (rState == S_ACC) || (rState == S_SUM) || beatFirst;

  always_comb begin
    tapA = '0;
    tapB = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rBeatAddr == 5'(i)) tapA = rTap[i];
    end
    for (int i = 0; i <= 9; i++) begin
      if (rBeatAddr == 5'(i)) tapB = rTap[i + 11];
    end
  end

  assign prod1 = PROD_W'(tapA) * PROD_W'(sram.iRdData1);
  assign prod2 = PROD_W'(tapB) * PROD_W'(sram.iRdData2);

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rAcc1 <= '0;
      rAcc2 <= '0;
    end else if (beat) begin
      if (rBeatAddr == 5'd0) begin
        rAcc1 <= ACC_W'(prod1);
        rAcc2 <= ACC_W'(prod2);
      end else begin
        rAcc1 <= rAcc1 + ACC_W'(prod1);
        if (rBeatAddr != 5'd10) rAcc2 <= rAcc2 + ACC_W'(prod2);
      end
    end
  end

  // A held sample is always older than a new strobe, so it shifts first and
  // the new one takes its place in the pending register.
  assign doShift = !busyNow && (rPendValid || iEnSample600k);
  assign shiftIn = rPendValid ? rPend : iFirIn;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < N_TAPS; i++) rTap[i] <= '0;
      rPend      <= '0;
      rPendValid <= 1'b0;
      oOverrun   <= 1'b0;
    end else begin
      if (doShift) begin
        rTap[0] <= shiftIn;
        for (int i = 1; i < N_TAPS; i++) rTap[i] <= rTap[i - 1];
      end
      if (iEnSample600k && (busyNow || rPendValid)) begin
        rPend      <= iFirIn;
        rPendValid <= 1'b1;
        if (busyNow && rPendValid) oOverrun <= 1'b1;
      end else if (doShift) begin
        rPendValid <= 1'b0;
      end
    end
  end

  assign rounded = (rSum + ROUND_HALF) >>> FRAC_W;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [SUM_W-1:0] OUT_MAX = (SUM_W'(1) <<< (DATA_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = -(SUM_W'(1) <<< (DATA_W - 1));

  always_comb begin
    if (rounded > OUT_MAX)      outVal = OUT_MAX[DATA_W-1:0];
    else if (rounded < OUT_MIN) outVal = OUT_MIN[DATA_W-1:0];
    else                        outVal = rounded[DATA_W-1:0];
  end
`else
  logic unusedRoundHi;
  assign unusedRoundHi = ^rounded[SUM_W-1:DATA_W];
  assign outVal        = rounded[DATA_W-1:0];
`endif

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rState       <= S_IDLE;
      rSum         <= '0;
      oFirOut      <= '0;
      oFirOutValid <= 1'b0;
    end else begin
      oFirOutValid <= 1'b0;
      case (rState)
        S_IDLE: if (beatFirst) rState <= S_ACC;
        S_ACC:  if (beatLast) rState <= S_SUM;
        S_SUM: begin
          rSum   <= SUM_W'(rAcc1) + SUM_W'(rAcc2);
          rState <= S_WAIT;
        end
        S_WAIT: begin
          if (iEnOut) begin
            oFirOut      <= outVal;
            oFirOutValid <= 1'b1;
            rState       <= S_IDLE;
          end
        end
        default: rState <= S_IDLE;
      endcase
    end
  end
endmodule
